// File: rtl/kinnow_mem_master.sv
// kinnow_mem_master: CPU load/store initiator for the 128K DRAM. Sub-word stores
// are read-modify-write; each DRAM wait state aborts after TIMEOUT stalled cycles.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | ready for a request; decodes errors on accept
// S_RD      | read address presented to the DRAM for one cycle
// S_RD_WAIT | waiting on mem_rdy for read data (load, or RMW fetch)
// S_WR      | single-cycle write strobe with full or merged word
// S_WR_WAIT | waiting on mem_rdy for write completion
// S_RESP    | response held until the consumer takes it
module kinnow_mem_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rdy_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD      = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic        req_err;
  logic [7:0]  cnt_inc;
  logic        timed_out;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged;

  // Stores are only legal in the low 64K; the upper bank is read-only.
  assign req_err = (req_size_i == 2'd3)
                || (req_size_i == 2'd1 && req_addr_i[0])
                || (req_size_i == 2'd2 && req_addr_i[1:0] != 2'b00)
                || (req_we_i && req_addr_i[31:16] != 16'h0000);

  assign cnt_inc   = cnt_q + 8'd1;
  assign timed_out = !mem_rdy_i && (cnt_inc == TIMEOUT_C);

  assign byte_sh  = {lane_q, 3'b000};
  assign half_sh  = {lane_q[1], 4'b0000};
  assign byte_sel = mem_rdata_i[byte_sh +: 8];
  assign half_sel = mem_rdata_i[half_sh +: 16];

  always_comb begin
    load_data = mem_rdata_i;
    lane_mask = 32'hFFFF_FFFF;
    lane_data = 32'h0000_0000;
    case (size_q)
      2'd0: begin
        load_data = {{24{signed_q & byte_sel[7]}}, byte_sel};
        lane_mask = 32'h0000_00FF << byte_sh;
        lane_data = {24'h000000, wdata_q[7:0]} << byte_sh;
      end
      2'd1: begin
        load_data = {{16{signed_q & half_sel[15]}}, half_sel};
        lane_mask = 32'h0000_FFFF << half_sh;
        lane_data = {16'h0000, wdata_q} << half_sh;
      end
      default: begin
        load_data = mem_rdata_i;
        lane_mask = 32'hFFFF_FFFF;
        lane_data = 32'h0000_0000;
      end
    endcase
    merged = (mem_rdata_i & ~lane_mask) | lane_data;
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i && ready_q) begin
          we_d     = req_we_i;
          size_d   = req_size_i;
          signed_d = req_signed_i;
          lane_d   = req_addr_i[1:0];
          wdata_d  = req_wdata_i[15:0];
          if (req_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'h0000_0000;
            resp_err_d   = 1'b1;
          end else if (req_we_i && req_size_i == 2'd2) begin
            state_d     = S_WR;
            mem_addr_d  = {req_addr_i[31:2], 2'b00};
            mem_we_d    = 1'b1;
            mem_wdata_d = req_wdata_i;
          end else begin
            state_d    = S_RD;
            mem_addr_d = {req_addr_i[31:2], 2'b00};
          end
        end
      end

      S_RD: begin
        state_d = S_RD_WAIT;
        cnt_d   = 8'd0;
      end

      S_RD_WAIT: begin
        if (mem_rdy_i) begin
          if (we_q) begin
            state_d     = S_WR;
            mem_we_d    = 1'b1;
            mem_wdata_d = merged;
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = load_data;
            resp_err_d   = 1'b0;
          end
        end else if (timed_out) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'h0000_0000;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WR: begin
        state_d = S_WR_WAIT;
        cnt_d   = 8'd0;
      end

      S_WR_WAIT: begin
        if (mem_rdy_i || timed_out) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = 32'h0000_0000;
          resp_err_d   = !mem_rdy_i;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RESP: begin
        if (resp_ready_i) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Registered so that ready stays low throughout reset and rises one cycle after release.
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      lane_q       <= 2'd0;
      wdata_q      <= 16'h0000;
      cnt_q        <= 8'd0;
      mem_addr_q   <= 32'h0000_0000;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      we_q         <= we_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_kinnow_mem_master.sv
// Scoreboard bench for kinnow_mem_master: a byte-array reference memory predicts
// responses, write pulses and latencies; monitors compare whatever the DUT presents.
module tb_kinnow_mem_master;
  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_rdy;

  kinnow_mem_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_rdy_i(mem_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wexp_t;

  exp_t  sbq[$];
  wexp_t wq[$];

  logic [31:0] dram [0:32767];
  logic [7:0]  ref_b [0:131071];
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int bp_mode = 0;

  // DRAM: read data registered one edge after the address; write on mem_we.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) dram[mem_addr[16:2]] <= mem_wdata;
    mem_rdata <= dram[mem_addr[16:2]];
  end

  initial begin
    resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       resp_ready = 1'b1;
        1:       resp_ready = 1'($urandom_range(0, 1));
        default: resp_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  exp_t  m_e;
  wexp_t m_w;
  logic  rv_prev = 1'b0;

  always @(negedge clk) begin
    if (resp_valid) begin
      check("req_ready_low_in_resp", {31'b0, req_ready}, 32'd0);
      if (!rv_prev) begin
        if (sbq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_resp: got rdata %h err %b, required no response", resp_rdata, resp_err);
        end else begin
          check("resp_latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
        end
      end
      if (resp_ready && sbq.size() != 0) begin
        m_e = sbq.pop_front();
        check("resp_rdata", resp_rdata, m_e.rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, m_e.err});
      end
    end
    rv_prev = resp_valid;
    if (mem_we) begin
      if (wq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_mem_we: got addr %h data %h, required no write", mem_addr, mem_wdata);
      end else begin
        m_w = wq.pop_front();
        check("mem_we_addr", mem_addr, m_w.addr);
        check("mem_we_data", mem_wdata, m_w.data);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int extra, input bit tmo, input bit no_resp);
    exp_t  e;
    wexp_t w;
    logic  err;
    int    nb;
    int    base;
    int    guard;
    logic [31:0] v;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
       || (we && a[31:16] != 16'h0000);
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(a[16:0]);
    v    = 32'h0;
    w.addr = {a[31:2], 2'b00};
    w.data = 32'h0;
    if (err) begin
      e.lat = 1;
    end else if (we) begin
      for (int i = 0; i < nb; i++) ref_b[base + i] = wd[8*i +: 8];
      for (int i = 0; i < 4; i++) w.data[8*i +: 8] = ref_b[(base & ~3) + i];
      e.lat = (sz == 2'd2) ? 3 : 5;
    end else begin
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_b[base + i];
      if (sg && nb == 1 && v[7])  v[31:8]  = 24'hFFFFFF;
      if (sg && nb == 2 && v[15]) v[31:16] = 16'hFFFF;
      e.lat = 3;
    end
    e.rdata = (err || we || tmo) ? 32'h0 : v;
    e.err   = err || tmo;
    if (tmo) e.lat = 2 + TIMEOUT;
    e.lat = e.lat + extra;

    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!req_ready) begin
      n_total++;
      $display("FAIL accept_timeout: got req_ready 0, required 1 within 500 cycles");
    end else begin
      e.acc = cyc;
      if (!no_resp) sbq.push_back(e);
      if (!err && we) wq.push_back(w);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = $urandom;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sbq.size() != 0 || wq.size() != 0 || !req_ready) && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 2000) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sbq.size());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic        rwe;
    logic [1:0]  rsz;
    logic [31:0] ra;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_rdy = 1'b1;
    for (int i = 0; i < 32768; i++) begin
      w = $urandom;
      if (i == 32'h10004 / 4) w = 32'hDEADBEEF;
      dram[i] = w;
      for (int j = 0; j < 4; j++) ref_b[4*i + j] = w[8*j +: 8];
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_release", {31'b0, req_ready}, 32'd1);

    // directed: ROM word load, word store + reload, byte RMW, signed/unsigned byte loads
    issue(1'b0, 2'd2, 1'b0, 32'h0001_0004, 32'h0, 0, 1'b0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h1234_5678, 0, 1'b0, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b0, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h0000_0012, 32'h0000_00AB, 0, 1'b0, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0012, 32'h0, 0, 1'b0, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h0000_0012, 32'h0, 0, 1'b0, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'h0, 0, 1'b0, 1'b0);
    // errors
    issue(1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'h0, 0, 1'b0, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h0001_0000, 32'hCAFE_F00D, 0, 1'b0, 1'b0);
    issue(1'b0, 2'd3, 1'b0, 32'h0000_0020, 32'h0, 0, 1'b0, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h0001_0001, 32'h55, 0, 1'b0, 1'b0);
    drain();

    // five-cycle stall in RD_WAIT
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 5, 1'b0, 1'b0);
    mem_rdy = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    mem_rdy = 1'b1;
    drain();

    // DRAM never ready: timeout
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0, 1'b1, 1'b0);
    mem_rdy = 1'b0;
    drain();
    mem_rdy = 1'b1;
    drain();

    // backpressure: response held for 4 cycles
    bp_mode = 2;
    @(posedge clk);
    #2;
    issue(1'b0, 2'd2, 1'b0, 32'h0001_0004, 32'h0, 0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      check("bp_resp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_resp_rdata", resp_rdata, 32'hDEADBEEF);
      check("bp_resp_err", {31'b0, resp_err}, 32'd0);
      check("bp_req_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    bp_mode = 0;
    drain();

    // reset during the write strobe of a byte store: no response afterwards
    issue(1'b1, 2'd0, 1'b0, 32'h0000_0021, 32'h0000_005A, 0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("we_in_wr", {31'b0, mem_we}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_wr_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_wr_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_wr_resp_valid", {31'b0, resp_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wr_ready_after", {31'b0, req_ready}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    issue(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 0, 1'b0, 1'b0);
    drain();

    // randomized traffic with random backpressure
    bp_mode = 1;
    for (int n = 0; n < 200; n++) begin
      rwe = 1'($urandom_range(0, 1));
      rsz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ra  = 32'($urandom_range(0, 255));
      if (!rwe || $urandom_range(0, 9) == 0) ra[16] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        if (rsz == 2'd1) ra[0] = 1'b0;
        if (rsz == 2'd2) ra[1:0] = 2'b00;
      end
      if (!rwe && $urandom_range(0, 19) == 0) ra[31:24] = 8'($urandom);
      issue(rwe, rsz, 1'($urandom_range(0, 1)), ra, $urandom, 0, 1'b0, 1'b0);
    end
    bp_mode = 0;
    drain();
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/kinnow_mem_master.md
# kinnow_mem_master

Bus initiator for the 128K DRAM. Accepts byte/half/word load and store requests from the CPU core over a valid/ready handshake. Drives the DRAM's word-wide address/we/data port and waits on its rdy. Performs read-modify-write for sub-word stores, and returns aligned, extended load data or an error status.

## Interface
- TIMEOUT, 16: cycles a wait state tolerates mem_rdy=0 before aborting with an error (1..255).
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; synchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  load data (0 for stores and errors).
- resp_err  out  1  request failed.
- mem_addr  out  32  DRAM address, always word-aligned ({addr[31:2],2'b00}).
- mem_we  out  1  DRAM write enable.
- mem_wdata  out  32  DRAM write data.
- mem_rdata  in  32  DRAM read data, registered one edge after mem_addr.
- mem_rdy  in  1  DRAM ready.

## Operation
- States: IDLE, RD, RD_WAIT, WR, WR_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch the request and decode errors.
  - Error → RESP with err=1, and no mem_we pulse.
  - Word store → WR.
  - Any load or sub-word store → RD.
- Errors:
  - req_size=3.
  - Half with addr[0]=1.
  - Word with addr[1:0]≠0.
  - Any store with addr[31:16]≠16'h0000 (read-only bank).
  - Loads to any address are legal.
- RD:
  - Drive mem_addr, mem_we=0, for one cycle; go to RD_WAIT.
- RD_WAIT:
  - mem_rdy=1: capture mem_rdata. A load goes to RESP. A store merges and goes to WR.
  - mem_rdy=0: increment the wait counter. When it reaches TIMEOUT, go to RESP with err=1 and rdata=0.
- WR:
  - mem_we=1 for exactly one cycle, with mem_addr and mem_wdata (full or merged word).
  - Then go to WR_WAIT.
- WR_WAIT:
  - Same mem_rdy/timeout rule as RD_WAIT; go to RESP. mem_we=0 here.
- RESP:
  - resp_valid=1, with resp_rdata/resp_err stable until resp_ready.
  - On resp_valid&&resp_ready → IDLE; resp_valid deasserts the next cycle.
- Byte lanes are little-endian; lane = addr[1:0] (half uses addr[1]).
- Loads: the selected lane is right-justified, then zero-extended, or sign-extended when req_signed.
- Sub-word stores: only the selected lane(s) of the read word are replaced with req_wdata[7:0] or [15:0]. Other bits are unchanged.
- The wait counter is 8 bits and clears on each entry to RD_WAIT or WR_WAIT.

## Timing
- Reset values:
  - State IDLE.
  - req_ready=0 while rst=0, then 1 on the first cycle after release.
  - resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_addr=0, mem_we=0, mem_wdata=0.
- Latency numbering: the accept cycle is cycle 0.
  - Word load: resp_valid in cycle 3.
  - Word store: mem_we in cycle 1, resp_valid in cycle 3.
  - Sub-word store: mem_we in cycle 3, resp_valid in cycle 5.
  - Error: resp_valid in cycle 1.
  - Each mem_rdy=0 cycle in a wait state adds one cycle.
- Only one request is outstanding at a time. req_valid is ignored outside IDLE.
- mem_addr holds from RD through WR_WAIT. In IDLE and RESP it keeps its last value.
- A simultaneous resp_ready and new req_valid in RESP does not accept the request; acceptance happens in the following IDLE cycle.
- rst=0 in any state returns to IDLE on that edge:
  - mem_we drops.
  - Any pending response is discarded.
  - No merged write is issued.

## Test plan
- Word load (ROM bank):
  - Preload DRAM rom word 0x1 = 0xDEADBEEF.
  - Load word at 0x0001_0004.
  - Expect resp_valid in cycle 3, rdata=0xDEADBEEF, err=0.
- Word store then load-back:
  - Store 0x12345678 to 0x0000_0010.
  - Expect a single mem_we pulse at mem_addr 0x10 in cycle 1.
  - Reload returns 0x12345678.
- Sub-word store and signed byte load:
  - Store byte 0xAB to 0x0000_0012 over word 0x12345678.
  - Expect a RD then a WR pulse with mem_wdata=0x12AB5678, resp in cycle 5.
  - Signed byte load at 0x12 returns 0xFFFFFFAB; unsigned returns 0x000000AB.
- Errors:
  - Half load at 0x0000_0003 → err=1 in cycle 1.
  - Store to 0x0001_0000 → err=1, and mem_we never asserts.
  - size=3 → err=1.
- Stall and timeout:
  - Hold mem_rdy=0 for 5 cycles → response delayed by 5 cycles, err=0.
  - Hold mem_rdy=0 permanently → err=1 after TIMEOUT cycles in RD_WAIT.
- Backpressure and reset:
  - Hold resp_ready=0 for 4 cycles → resp fields stable and req_ready=0.
  - Assert rst in WR of a sub-word store → mem_we=0 the next cycle, IDLE, no response.
